// File: rtl/pic_pkg.sv
// Shared definitions for the CPU-side interrupt acknowledge sequencer:
// FSM state encoding and the default INTA timing used by the PIC model.
package pic_pkg;

    // Acknowledge cycle states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK1 = 3'd1,
        ST_GAP  = 3'd2,
        ST_ACK2 = 3'd3,
        ST_VEC  = 3'd4
    } state_t;

    // Default timing shared with the PIC control model
    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_ACK_PULSE_CYCLES = 2;
    localparam int DEF_ACK_GAP_CYCLES   = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pic_sync.sv
// SYNC_STAGES-deep single-bit synchronizer with asynchronous active-low reset.
// A depth of 0 degenerates to a wire for same-clock sources.
module pic_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = clk ^ reset_n;
            assign q = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            // Shift the input one stage deeper every clock
            always_comb begin
                sync_d[0] = d;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Synchronizer flops, cleared asynchronously
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= sync_d;
            end

            assign q = sync_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side end of the PIC INT/INTA handshake. On a synchronized INT with
// interrupts enabled, drives two INTA pulses, captures the vector byte at the
// end of the second pulse and offers it to the core over valid/ready.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int ACK_PULSE_CYCLES = DEF_ACK_PULSE_CYCLES,
    parameter int ACK_GAP_CYCLES   = DEF_ACK_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       int_req,
    input  logic       int_enable,
    input  logic [7:0] data_in,
    output logic       int_ack,
    output logic       busy,
    output logic       vector_valid,
    output logic [7:0] vector,
    input  logic       vector_ready
);

    localparam int CNT_MAX = max_int(ACK_PULSE_CYCLES, ACK_GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(ACK_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(ACK_GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (ACK_PULSE_CYCLES < 1) begin : g_bad_pulse
            $error("inta_sequencer: ACK_PULSE_CYCLES must be >= 1");
        end
        if (ACK_GAP_CYCLES < 1) begin : g_bad_gap
            $error("inta_sequencer: ACK_GAP_CYCLES must be >= 1");
        end
        if (SYNC_STAGES < 0) begin : g_bad_sync
            $error("inta_sequencer: SYNC_STAGES must be >= 0");
        end
    endgenerate

    logic             int_req_s;
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [7:0]       vector_q, vector_d;

    pic_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (int_req),
        .q       (int_req_s)
    );

    // State, phase counter and vector register; reset drops INTA immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            vector_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vector_q <= vector_d;
        end
    end

    // Next state, counter reload on each state entry, and Moore outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vector_d     = vector_q;
        int_ack      = 1'b0;
        busy         = 1'b1;
        vector_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                // Only IDLE looks at int_enable; running sequences always finish
                if (int_req_s && int_enable) begin
                    state_d = ST_ACK1;
                    cnt_d   = PULSE_LD;
                end
            end
            ST_ACK1: begin
                int_ack = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_ACK2;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACK2: begin
                int_ack = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    // PIC is driving the vector during the last ACK2 cycle
                    state_d  = ST_VEC;
                    cnt_d    = '0;
                    vector_d = data_in;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_VEC: begin
                vector_valid = 1'b1;
                // Returning to IDLE guarantees one idle cycle before re-arming
                if (vector_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign vector = vector_q;

endmodule
